// File: rtl/program_launcher.sv
// Arbitrated program launcher: turns level request lines into one launch at a time.
// Each launch holds program_selector for a copy window, then waits for done or a timeout.
module program_launcher #(
  parameter int NUM_PROGS   = 5,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 4096,
  parameter int SEL_W       = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PROGS-1:0] req,
  input  logic                 done,
  output logic [SEL_W-1:0]     program_selector,
  output logic [NUM_PROGS-1:0] grant,
  output logic                 launch,
  output logic                 busy,
  output logic                 timed_out
);

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_e;

  state_e               state_q, state_d;
  logic [NUM_PROGS-1:0] req_q;
  logic [NUM_PROGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_PROGS-1:0] grant_q, grant_d;
  logic                 launch_q, launch_d;
  logic                 busy_q, busy_d;
  logic                 to_q, to_d;

  logic [NUM_PROGS-1:0] rise, cand, win_oh;
  logic [SEL_W-1:0]     win_sel;
  logic                 win_found;

  assign rise = req & ~req_q;
  assign cand = pend_q | rise;

  // Fixed priority: scanning downward lets the lowest set index overwrite the others.
  always_comb begin
    win_found = 1'b0;
    win_oh    = '0;
    win_sel   = '0;
    for (int i = NUM_PROGS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_oh    = NUM_PROGS'(1) << i;
        win_sel   = SEL_W'(i + 1);
      end
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    pend_d   = cand;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    launch_d = 1'b0;
    busy_d   = busy_q;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = HOLD;
          pend_d   = cand & ~win_oh;
          sel_d    = win_sel;
          grant_d  = win_oh;
          launch_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = HOLD_LAST;
          to_d     = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          sel_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (done || cnt_q == RUN_LAST) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          to_d    = ~done;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: req_q samples even during reset so a button held through reset never looks like a new press.
    req_q <= req;
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      grant_q  <= '0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
    end
  end

  assign program_selector = sel_q;
  assign grant            = grant_q;
  assign launch           = launch_q;
  assign busy             = busy_q;
  assign timed_out        = to_q;

endmodule

// File: doc/program_launcher.md
Name: program_launcher

Overview:
Sequences program launches on the RISC processor. It turns level-sensitive program requests (fib, sort, save, load, pusha buttons) into one arbitrated launch at a time. Each launch drives program_selector into the register file for a guaranteed multi-cycle copy window, then returns it to 0 and waits for the processor's done indication or a timeout. It replaces the ad-hoc per-cycle if-chain that fed program_selector.

Parameters:
NUM_PROGS, 5, number of request lines; bit i selects program i+1
HOLD_CYCLES, 4, cycles program_selector is held non-zero per launch (>=1)
TIMEOUT, 4096, max cycles in RUN before forced return to IDLE (>=2)
SEL_W, 32, width of program_selector

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
req  in  NUM_PROGS  level requests; bit0 fib, bit1 sort, bit2 save, bit3 load, bit4 pusha
done  in  1  processor reports program complete; sampled only in RUN
program_selector  out  SEL_W  to regfile; 0 = no program
grant  out  NUM_PROGS  one-hot program currently launched/running; 0 in IDLE
launch  out  1  one-cycle pulse on the first HOLD cycle
busy  out  1  high in HOLD and RUN
timed_out  out  1  sticky; set when RUN ends by timeout, cleared at next launch or reset

Behaviour:
- All outputs registered. Reset values: program_selector=0, grant=0, launch=0, busy=0, timed_out=0, state=IDLE, pend=0, cnt=0.
- Edge detect: req_q <= req every cycle, including during reset, so a button held through reset never launches. rise = req & ~req_q.
- Pending set: pend <= (pend | rise) & ~granted_bit. Repeated rises of an already-pending bit merge into one request. Rises in any state are latched.
- Arbitration: fixed priority, lowest index wins (fib > sort > save > load > pusha). Candidates are pend | rise.
- IDLE: if candidates != 0, grant the winner i at this edge and go to HOLD. Set program_selector=i+1 (zero-extended to SEL_W), grant=1<<i, launch=1, busy=1, cnt=HOLD_CYCLES-1, timed_out=0. Latency is 1 edge from the first req-high sample to a valid program_selector.
- HOLD: launch=0 after the first cycle. program_selector stays i+1 for exactly HOLD_CYCLES cycles. When cnt==0, go to RUN with program_selector=0 and cnt=0. Otherwise cnt decrements. done is ignored in HOLD.
- RUN: program_selector=0 and grant is held. cnt increments each cycle.
  - If done=1, go to IDLE: grant=0, busy=0.
  - Else if cnt==TIMEOUT-1, go to IDLE and set timed_out=1.
  - If done and timeout coincide, done wins and timed_out stays 0.
- Back-to-back: on return to IDLE, a pending request launches on the next edge. There is exactly one IDLE cycle between launches.
- Simultaneous rises: the highest-priority rise launches; the others remain pending and are served in priority order.
- Reset mid-operation: returns to the reset state next edge, clears pend and drops program_selector to 0. No request is remembered.
- Counter width is clog2(max(HOLD_CYCLES,TIMEOUT))+1 bits. No wrap occurs because the terminal compare happens before overflow.

Test Plan:
- Reset then pulse req[0] for 2 cycles (HOLD_CYCLES=4): program_selector=1 on the 4 edges after the first sample; launch high 1 cycle; grant=5'b00001; busy high; done after 10 cycles -> busy=0, grant=0.
- Assert req=5'b10110 on one edge: launches 2 (sort), then 3 (save), then 5 (pusha) in that order. Pulse done each RUN. Exactly one IDLE cycle between launches.
- Pulse req[3] twice during a fib RUN: exactly one load launch (program_selector=4) follows the fib done.
- TIMEOUT=16, launch save, never assert done: RUN lasts 16 cycles, then IDLE with timed_out=1. The next launch clears timed_out.
- Hold req[1] high through reset and release 5 cycles later: no launch occurs. Re-press -> program_selector=2.
- Assert reset during HOLD of pusha with req[0] pending: next edge program_selector=0, busy=0, pend=0. No launch follows without a new rise.
